// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-decimal display decoder with registered one-hot outputs.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_BLANK_EN.
module bcd_scan_decoder #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     sel,
    output logic [9:0]            dec,
    output logic                  err,
    output logic                  frame
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_q;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wrap_q, wrap_d;
    logic                tick;
    logic [3:0]          digit;
    logic                blank;
    logic [DIGITS-1:0]   sel_d;
    logic [9:0]          dec_d;
    logic                err_d;

    assign tick = en && (pcnt_q == PMAX);

    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
        if (tick) begin
            if (idx_q == IMAX) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

`ifdef BCD_SCAN_BLANK_EN
    // lead_zero[i]: digit i and every digit above it are zero.
    logic [DIGITS-1:0] lead_zero;
    logic              zrun;

    always_comb begin
        lead_zero = '0;
        zrun      = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zrun         = zrun && (shadow_q[4*i +: 4] == 4'd0);
            lead_zero[i] = zrun;
        end
    end
`endif

    always_comb begin
        digit = '0;
        blank = 1'b0;
        sel_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                digit    = shadow_q[4*i +: 4];
                sel_d[i] = en;
`ifdef BCD_SCAN_BLANK_EN
                blank    = lead_zero[i] && (i != 0);
`endif
            end
        end
        err_d = en && (digit > 4'd9);
        dec_d = (en && (digit <= 4'd9) && !blank) ? (10'd1 << digit) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            sel      <= '0;
            dec      <= '0;
            err      <= 1'b0;
            frame    <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= bcd;
            end
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            sel    <= sel_d;
            dec    <= dec_d;
            err    <= err_d;
            // Delayed by one so the pulse lines up with digit 0 reaching the outputs.
            frame  <= en && wrap_q;
        end
    end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed bench for bcd_scan_decoder: a 4-digit/div-4 instance and a 1-digit/div-1 instance.
module tb_bcd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] bcd;
    logic [3:0]  sel;
    logic [9:0]  dec;
    logic        err, frame;

    logic        rst1, en1, load1;
    logic [3:0]  bcd1;
    logic [0:0]  sel1;
    logic [9:0]  dec1;
    logic        err1, frame1;

    int nvec = 0;
    int nerr = 0;

`ifdef BCD_SCAN_BLANK_EN
    localparam logic [9:0] BLANK_DEC = 10'd0;
`else
    localparam logic [9:0] BLANK_DEC = 10'd1;
`endif

    always #5 clk = ~clk;

    bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .bcd   (bcd),
        .sel   (sel),
        .dec   (dec),
        .err   (err),
        .frame (frame)
    );

    bcd_scan_decoder #(.DIGITS(1), .SCAN_DIV(1)) dut1 (
        .clk   (clk),
        .rst   (rst1),
        .en    (en1),
        .load  (load1),
        .bcd   (bcd1),
        .sel   (sel1),
        .dec   (dec1),
        .err   (err1),
        .frame (frame1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nfr;
        int d;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd = '0;
        rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; bcd1 = '0;
        repeat (2) step();
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_dec", 32'(dec), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_frame", 32'(frame), 32'h0);

        rst = 1'b0; en = 1'b1;
        step();
        check_eq("first_sel", 32'(sel), 32'h1);
        check_eq("first_dec", 32'(dec), 32'h1);

        // Restart from a clean scan with 1234 preloaded while disabled.
        rst = 1'b1; #1; rst = 1'b0;
        en = 1'b0; load = 1'b1; bcd = 16'h1234;
        step();
        load = 1'b0;
        check_eq("dis_sel", 32'(sel), 32'h0);
        en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            d = (k - 1) / 4;
            check_eq("scan_sel", 32'(sel), 32'(1 << d));
            check_eq("scan_dec", 32'(dec), 32'(1 << (4 - d)));
            check_eq("scan_frame", 32'(frame), 32'h0);
        end
        step();
        check_eq("wrap_frame", 32'(frame), 32'h1);
        check_eq("wrap_sel", 32'(sel), 32'h1);
        check_eq("wrap_dec", 32'(dec), 32'h10);
        nfr = 0;
        for (int k = 18; k <= 33; k++) begin
            step();
            nfr += int'(frame);
        end
        check_eq("frame_count", 32'(nfr), 32'd1);
        check_eq("frame_period", 32'(frame), 32'h1);

        // 00A5: illegal digit 1, leading zeros on digits 2 and 3.
        load = 1'b1; bcd = 16'h00A5;
        step();
        load = 1'b0;
        check_eq("load_old", 32'(dec), 32'h10);
        step();
        check_eq("load_new", 32'(dec), 32'h20);
        step();
        step();
        check_eq("ill_sel", 32'(sel), 32'h2);
        check_eq("ill_err", 32'(err), 32'h1);
        check_eq("ill_dec", 32'(dec), 32'h0);
        repeat (3) step();
        step();
        check_eq("d2_sel", 32'(sel), 32'h4);
        check_eq("d2_dec", 32'(dec), 32'(BLANK_DEC));
        check_eq("d2_err", 32'(err), 32'h0);
        repeat (3) step();
        step();
        check_eq("d3_sel", 32'(sel), 32'h8);
        check_eq("d3_dec", 32'(dec), 32'(BLANK_DEC));
        repeat (3) step();
        step();
        check_eq("a5_frame", 32'(frame), 32'h1);
        check_eq("a5_dec", 32'(dec), 32'h20);

        // Freeze mid-digit for 10 cycles, then resume.
        step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("frz_out", {16'h0, sel, dec, err, frame}, 32'h0);
        end
        en = 1'b1;
        step();
        check_eq("res_sel0", 32'(sel), 32'h1);
        check_eq("res_dec0", 32'(dec), 32'h20);
        step();
        check_eq("res_sel1", 32'(sel), 32'h1);
        step();
        check_eq("res_sel2", 32'(sel), 32'h2);
        check_eq("res_err2", 32'(err), 32'h1);

        // Load on the same edge as a tick.
        repeat (2) step();
        load = 1'b1; bcd = 16'h0786;
        step();
        load = 1'b0;
        check_eq("lt_sel", 32'(sel), 32'h2);
        check_eq("lt_err", 32'(err), 32'h1);
        step();
        check_eq("lt_nsel", 32'(sel), 32'h4);
        check_eq("lt_ndec", 32'(dec), 32'h80);
        check_eq("lt_nerr", 32'(err), 32'h0);

        // Asynchronous reset at idx=2, pcnt=3.
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out", {16'h0, sel, dec, err, frame}, 32'h0);
        step();
        rst = 1'b0;
        step();
        check_eq("post_sel", 32'(sel), 32'h1);
        check_eq("post_dec", 32'(dec), 32'h1);
        repeat (3) step();
        step();
        check_eq("post_d1_sel", 32'(sel), 32'h2);
        check_eq("post_d1_dec", 32'(dec), 32'(BLANK_DEC));

        // Single digit, divide by one.
        rst1 = 1'b0; en1 = 1'b1; load1 = 1'b1; bcd1 = 4'h9;
        step();
        load1 = 1'b0;
        check_eq("s1_sel", 32'(sel1), 32'h1);
        check_eq("s1_dec", 32'(dec1), 32'h1);
        check_eq("s1_frame", 32'(frame1), 32'h0);
        for (int k = 0; k < 7; k++) begin
            step();
            check_eq("s1_run_sel", 32'(sel1), 32'h1);
            check_eq("s1_run_dec", 32'(dec1), 32'h200);
            check_eq("s1_run_frame", 32'(frame1), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Registered, time-multiplexed BCD-to-decimal decoder for multi-digit displays. Holds a packed word of DIGITS BCD digits, scans them one at a time at a programmable rate, and drives a one-hot decimal code plus a one-hot digit select for the currently scanned digit. It sits between the counter/arithmetic datapath and the board display driver, replacing per-digit combinational decoders.

## Interface
- DIGITS, 4: number of BCD digits scanned (1..8)
- SCAN_DIV, 1000: clock cycles each digit is displayed (>=1)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; low freezes scan and blanks display
- load  input  1  capture `bcd` into shadow register on this edge
- bcd  input  4*DIGITS  packed digits, digit k at bits [4k+3:4k], digit 0 least significant
- sel  output  DIGITS  one-hot select of the displayed digit
- dec  output  10  one-hot decimal code of the displayed digit (dec[n] high for value n)
- err  output  1  displayed digit is an illegal code (10..15)
- frame  output  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0

## Operation
- State: shadow register (4*DIGITS), prescaler `pcnt` (0..SCAN_DIV-1), digit index `idx` (0..DIGITS-1), output registers.
- Load: `load`=1 captures `bcd` into shadow at the edge, independent of `en`.
- Prescaler: when `en`=1, `pcnt` increments each cycle; at SCAN_DIV-1 it returns to 0 and asserts internal `tick`. When `en`=0, `pcnt` and `idx` hold.
- Index: on `tick`, `idx` advances; DIGITS-1 wraps to 0 and sets `frame` for that one cycle. DIGITS=1: `idx` stays 0, `frame` pulses on every `tick`.
- Decode of digit d = shadow[4*idx+3:4*idx]: d<=9 -> dec = 1<<d, err=0; d>=10 -> dec = 0, err=1.
- With `en`=0: sel=0, dec=0, err=0; `frame` never pulses.
- Simultaneous `load` and `tick`: both take effect; the next displayed value uses the new shadow and new `idx`.
- `rst` mid-scan immediately clears all state and outputs regardless of clock.

## Timing
- Reset values: shadow=0, pcnt=0, idx=0, sel=0, dec=0, err=0, frame=0.
- All outputs are registered: `sel`/`dec`/`err` at edge N reflect `idx`, shadow and `en` as they were after edge N-1 (one-cycle latency).
- After `rst` deasserts with `en`=1: first edge gives sel=1 (digit 0), dec=10'b1 (shadow 0).
- `load` to visible change: 2 edges (capture, then output register) if the digit is currently selected.
- Each digit is held for exactly SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.
- `frame` is asserted in the same cycle as the output register first showing digit 0 of the new frame.

## Configuration
- BCD_SCAN_BLANK_EN defined: leading-zero blanking. Digits above the highest non-zero digit of the shadow that hold 0 output dec=0, err=0, while `sel` still selects them; digit 0 is never blanked. An illegal code counts as non-zero.
- Not defined: every digit is decoded as is, zeros show dec[0]=1.

## Test plan
- Reset then en=1, DIGITS=4, SCAN_DIV=4, load bcd=16'h1234 -> sel steps 0001,0010,0100,1000 every 4 cycles with dec = bit4, bit3, bit2, bit1; frame pulses once per 16 cycles.
- load bcd=16'h00A5 -> digit 1 shows err=1, dec=0; digit 0 shows dec[5]=1; with BLANK_EN digits 3,2 show dec=0, without them dec[0]=1.
- en=0 mid-frame for 10 cycles -> sel=dec=0, frame=0; on en=1 scan resumes from the same idx and pcnt.
- load asserted on the same edge as a tick -> new digit shows new shadow value two edges later, no glitch value.
- rst pulsed while idx=2, pcnt=3 -> all outputs 0 immediately; after release, digit 0 selected with dec[0]=1.
- SCAN_DIV=1, DIGITS=1 -> sel=1 constant, frame high every cycle after the first.
